// File: rtl/tile_mem_server.sv
// Memory-side responder for the matrix_mul tile interface: holds the 8x8 A/B operands,
// streams 4x4 tiles on the read channel and collects 64 results into an 8x8 C buffer.
module tile_mem_server #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_en,
    input  logic              ld_sel,
    input  logic [5:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ren,
    input  logic [3:0]        raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rready,
    output logic              rd_busy,
    input  logic              wen,
    input  logic [ACC_W-1:0]  wdata,
    output logic              wready,
    input  logic [5:0]        c_rd_addr,
    output logic [ACC_W-1:0]  c_rd_data,
    input  logic              c_clr,
    output logic              c_done,
    output logic              wr_ovf
);

    typedef enum logic {R_IDLE = 1'b0, R_BURST = 1'b1} rd_state_t;
    typedef enum logic {W_IDLE = 1'b0, W_ACK = 1'b1} wr_state_t;

    // Row-major 8x8 index of element i of 4x4 tile t: row = {t[1],i[3:2]}, col = {t[0],i[1:0]}.
    function automatic logic [5:0] tile_addr(input logic [1:0] t, input logic [3:0] i);
        return {t[1], i[3:2], t[0], i[1:0]};
    endfunction

    logic [DATA_W-1:0] r_mem_a [64];
    logic [DATA_W-1:0] r_mem_b [64];
    logic [ACC_W-1:0]  r_mem_c [64];

    rd_state_t         r_rd_state, w_rd_state_nxt;
    logic [3:0]        r_raddr, w_raddr_nxt;
    logic [4:0]        r_phase, w_phase_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic              r_rready, w_rready_nxt;
    logic              r_rd_busy, w_rd_busy_nxt;
    logic [5:0]        w_rd_elem;
    logic [DATA_W-1:0] w_rd_word;

    wr_state_t         r_wr_state, w_wr_state_nxt;
    logic              r_wready, w_wready_nxt;
    logic [6:0]        r_cnt, w_cnt_nxt;
    logic              r_c_done, w_c_done_nxt;
    logic              r_wr_ovf, w_wr_ovf_nxt;
    logic              w_capture;
    logic              w_cap_store;
    logic [ACC_W-1:0]  r_c_rd_data;

    assign rdata     = r_rdata;
    assign rready    = r_rready;
    assign rd_busy   = r_rd_busy;
    assign wready    = r_wready;
    assign c_done    = r_c_done;
    assign wr_ovf    = r_wr_ovf;
    assign c_rd_data = r_c_rd_data;

    // Host operand load port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            if (ld_sel) begin
                r_mem_b[ld_addr] <= ld_data;
            end else begin
                r_mem_a[ld_addr] <= ld_data;
            end
        end
    end

    // Element fetch for the current burst word; an invalid tile address streams zeros.
    always_comb begin
        w_rd_elem = tile_addr(r_raddr[1:0], r_phase[4:1]);
        if (r_raddr[2]) begin
            w_rd_word = '0;
        end else if (r_raddr[3]) begin
            w_rd_word = r_mem_b[w_rd_elem];
        end else begin
            w_rd_word = r_mem_a[w_rd_elem];
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_nxt;
        end
    end

    // Read FSM next-state: a burst spans 32 edges after the accept edge.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            R_IDLE:  w_rd_state_nxt = ren ? R_BURST : R_IDLE;
            R_BURST: w_rd_state_nxt = (r_phase == 5'd31) ? R_IDLE : R_BURST;
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    // Read FSM outputs: even phases present a new word with rready, odd phases hold it.
    always_comb begin
        w_raddr_nxt   = r_raddr;
        w_phase_nxt   = r_phase;
        w_rdata_nxt   = r_rdata;
        w_rready_nxt  = 1'b0;
        w_rd_busy_nxt = r_rd_busy;
        case (r_rd_state)
            R_IDLE: begin
                w_phase_nxt = 5'd0;
                w_rdata_nxt = '0;
                if (ren) begin
                    w_raddr_nxt   = raddr;
                    w_rd_busy_nxt = 1'b1;
                end else begin
                    w_rd_busy_nxt = 1'b0;
                end
            end
            R_BURST: begin
                if (r_phase == 5'd31) begin
                    w_phase_nxt   = 5'd0;
                    w_rdata_nxt   = '0;
                    w_rd_busy_nxt = 1'b0;
                end else begin
                    w_phase_nxt = r_phase + 5'd1;
                    if (!r_phase[0]) begin
                        w_rdata_nxt  = w_rd_word;
                        w_rready_nxt = 1'b1;
                    end else begin
                        w_rdata_nxt  = r_rdata;
                    end
                end
            end
            default: begin
                w_phase_nxt   = 5'd0;
                w_rdata_nxt   = '0;
                w_rd_busy_nxt = 1'b0;
            end
        endcase
    end

    // Read channel registered outputs and burst bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_raddr   <= 4'd0;
            r_phase   <= 5'd0;
            r_rdata   <= '0;
            r_rready  <= 1'b0;
            r_rd_busy <= 1'b0;
        end else begin
            r_raddr   <= w_raddr_nxt;
            r_phase   <= w_phase_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rready  <= w_rready_nxt;
            r_rd_busy <= w_rd_busy_nxt;
        end
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
        end
    end

    // Write FSM next-state: every W_ACK returns to idle, captured or aborted.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            W_IDLE:  w_wr_state_nxt = wen ? W_ACK : W_IDLE;
            W_ACK:   w_wr_state_nxt = W_IDLE;
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    // Write FSM outputs; c_clr wins over a capture on the same edge.
    always_comb begin
        w_wready_nxt = 1'b0;
        w_capture    = 1'b0;
        case (r_wr_state)
            W_IDLE:  w_wready_nxt = wen;
            W_ACK:   w_capture    = wen;
            default: w_wready_nxt = 1'b0;
        endcase
        w_cnt_nxt    = r_cnt;
        w_c_done_nxt = r_c_done;
        w_wr_ovf_nxt = r_wr_ovf;
        w_cap_store  = 1'b0;
        if (c_clr) begin
            w_cnt_nxt    = 7'd0;
            w_c_done_nxt = 1'b0;
            w_wr_ovf_nxt = 1'b0;
        end else if (w_capture) begin
            if (r_c_done) begin
                w_wr_ovf_nxt = 1'b1;
            end else begin
                w_cap_store  = 1'b1;
                w_cnt_nxt    = r_cnt + 7'd1;
                w_c_done_nxt = (r_cnt == 7'd63);
            end
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Write channel registered outputs, counter and flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wready <= 1'b0;
            r_cnt    <= 7'd0;
            r_c_done <= 1'b0;
            r_wr_ovf <= 1'b0;
        end else begin
            r_wready <= w_wready_nxt;
            r_cnt    <= w_cnt_nxt;
            r_c_done <= w_c_done_nxt;
            r_wr_ovf <= w_wr_ovf_nxt;
        end
    end

    // C buffer capture: results arrive in tile order, tile = cnt[5:4], element = cnt[3:0].
    always_ff @(posedge clk) begin
        if (w_cap_store) begin
            r_mem_c[tile_addr(r_cnt[5:4], r_cnt[3:0])] <= wdata;
        end
    end

    // Host C readback, one cycle of latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c_rd_data <= '0;
        end else begin
            r_c_rd_data <= r_mem_c[c_rd_addr];
        end
    end

endmodule

// File: doc/tile_mem_server.md
Name: tile_mem_server

Overview:
- Synthesizable memory-side responder for the matrix_mul tile interface.
- Holds full 8x8 A and B operand matrices and serves 4x4 tiles on the ren/raddr/rdata/rready read channel.
- Sinks the 64 result words from the wen/wdata/wready write channel into an 8x8 C buffer.
- Replaces the bench-only data source/sink, so the multiplier can be integrated on-chip with a host load/readback port.

Parameters:
DATA_W, 16, operand width (signed)
ACC_W, 32, result width (signed)

Ports:
clk  in  1  clock, rising-edge
rstn  in  1  asynchronous, active-low reset
ld_en  in  1  host operand write strobe
ld_sel  in  1  0=A, 1=B
ld_addr  in  6  row-major element index (row*8+col)
ld_data  in  DATA_W  operand value
ren  in  1  tile read request from initiator
raddr  in  4  [3]=0 A / 1 B; [2] must be 0; [1:0] tile index
rdata  out  DATA_W  streamed tile element
rready  out  1  rdata-valid strobe
rd_busy  out  1  read burst in progress
wen  in  1  result write request
wdata  in  ACC_W  result word
wready  out  1  write-accept strobe
c_rd_addr  in  6  host C readback index (row*8+col)
c_rd_data  out  ACC_W  C[c_rd_addr], registered, 1-cycle latency
c_clr  in  1  clears write counter, c_done, wr_ovf
c_done  out  1  64 results captured
wr_ovf  out  1  sticky: write accepted after c_done

Behaviour:
- Reset: rdata=0, rready=0, rd_busy=0, wready=0, c_done=0, wr_ovf=0, c_rd_data=0; read FSM=R_IDLE; write counter=0.
- A/B/C array contents are not reset.
- Tile map for tile t, element i (0..15, row-major 4x4):
  - global row = 4*t[1] + i[3:2]
  - global col = 4*t[0] + i[1:0]
  - t=0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- Read FSM, states R_IDLE and R_BURST:
  - Handshake: R_IDLE with ren=1 at edge E0 latches raddr, enters R_BURST, sets rd_busy=1.
  - Word k (0..15) timing: rdata=element k and rready=1 for exactly the cycle following edge E0+2k+1; rready=0 on the alternate cycles.
  - rdata holds its value through the low phase.
  - Burst end: at edge E0+32, rready=0, rdata=0, rd_busy=0, FSM returns to R_IDLE.
  - ren is ignored during R_BURST. If ren is still high in R_IDLE, a new burst starts; the initiator deasserts ren after the 16th rready.
  - Invalid raddr ([2]=1): the full 16-word burst is streamed with rdata=0.
  - rdata is read from the array at its update edge. A concurrent ld_en to the same element returns the old value; the new value is visible from the next cycle.
- Write FSM, states W_IDLE and W_ACK:
  - W_IDLE with wen=1 → wready=1, go to W_ACK.
  - W_ACK with wen=1 → capture wdata into C[map(cnt)], where tile = cnt[5:4] and i = cnt[3:0]. Then cnt++, wready=0, return to W_IDLE.
  - W_ACK with wen=0 → abort: no capture, no increment, wready=0, return to W_IDLE.
  - Minimum 2 cycles per word; the initiator holds wdata stable from wen rise through the capture edge.
- Counter and flags:
  - The capture raising cnt to 64 sets c_done on the same edge; cnt saturates at 64.
  - Handshakes after c_done still complete, but data is dropped and wr_ovf is set (sticky).
  - c_clr (synchronous) sets cnt=0, c_done=0, wr_ovf=0 and has priority over a simultaneous capture; C contents are kept.
- Channel independence: read and write channels run concurrently; ld_en is accepted at any time.
- Reset mid-operation: both FSMs abort immediately and all outputs go to their reset values. A partially streamed tile is restarted only by a new ren.

Test Plan:
- Load A[r][c]=8r+c; pulse ren with raddr=4'b0010 → rready high on cycles 1,3,…,31 after accept; rdata=32,33,34,35,40,…,59; rd_busy drops at cycle 32.
- Load B[r][c]=-(8r+c); raddr=4'b1001 → rdata=-4,-5,-6,-7,-12,…,-31.
- raddr=4'b0100 → 16 rready pulses with rdata=0; following raddr=4'b0000 burst correct (0,1,2,3,8,…).
- Write 64 words wdata=1000+k → C[0][4]=1016, C[4][0]=1032, C[7][7]=1063 via c_rd_addr; c_done rises on 64th capture; 65th write gives wready pulse, wr_ovf=1, C unchanged; c_clr clears both.
- wen dropped in W_ACK cycle → no capture, cnt unchanged; next full handshake writes C[0][0].
- rstn low at word 7 of a burst → rready/rdata/rd_busy 0 immediately; after release and new ren, full 16-word burst from element 0.
